// File: rtl/simd4_operand_packer.sv
// Packs four consecutive scalar (a, b) operand pairs into one four-lane bundle for the
// SIMD adder, with early close on in_last and zero-filled unused lanes.
module simd4_operand_packer #(
    parameter int width = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_a,
    input  logic [width-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] a0,
    output logic [width-1:0] a1,
    output logic [width-1:0] a2,
    output logic [width-1:0] a3,
    output logic [width-1:0] b0,
    output logic [width-1:0] b1,
    output logic [width-1:0] b2,
    output logic [width-1:0] b3,
    output logic [3:0]       lane_mask
);

    if (width < 1 || width > 12) begin : g_width_check
        $error("simd4_operand_packer: width must be within 1..12");
    end

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           state_q,     state_d;
    logic [1:0]       lane_cnt_q,  lane_cnt_d;
    logic [3:0]       mask_q,      mask_d;
    logic [width-1:0] lane_a_q [4];
    logic [width-1:0] lane_a_d [4];
    logic [width-1:0] lane_b_q [4];
    logic [width-1:0] lane_b_d [4];
    logic             ready_en_q;
    logic             accept_s;

    // in_ready stays low while reset is held and rises on the first edge after release
    assign in_ready  = ready_en_q & ((state_q == ST_FILL) | out_ready);
    assign out_valid = (state_q == ST_HOLD);
    assign accept_s  = in_valid & in_ready;

    // Next-state, lane-write and handshake logic
    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        mask_d     = mask_q;
        lane_a_d   = lane_a_q;
        lane_b_d   = lane_b_q;
        case (state_q)
            ST_FILL: begin
                if (accept_s) begin
                    lane_a_d[lane_cnt_q] = in_a;
                    lane_b_d[lane_cnt_q] = in_b;
                    mask_d[lane_cnt_q]   = 1'b1;
                    if (lane_cnt_q == 2'd3 || in_last) begin
                        state_d    = ST_HOLD;
                        lane_cnt_d = 2'd0;
                    end else begin
                        lane_cnt_d = lane_cnt_q + 2'd1;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    // Bundle leaves; a pair arriving in the same cycle opens the next one in lane 0
                    for (int i = 0; i < 4; i++) begin
                        lane_a_d[i] = {width{1'b0}};
                        lane_b_d[i] = {width{1'b0}};
                    end
                    mask_d     = 4'b0000;
                    state_d    = ST_FILL;
                    lane_cnt_d = 2'd0;
                    if (accept_s) begin
                        lane_a_d[0] = in_a;
                        lane_b_d[0] = in_b;
                        mask_d      = 4'b0001;
                        if (in_last) begin
                            state_d    = ST_HOLD;
                            lane_cnt_d = 2'd0;
                        end else begin
                            lane_cnt_d = 2'd1;
                        end
                    end else begin
                        lane_cnt_d = 2'd0;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d    = ST_FILL;
                lane_cnt_d = 2'd0;
                mask_d     = 4'b0000;
            end
        endcase
    end

    // State, lane storage and ready-enable registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FILL;
            lane_cnt_q <= 2'd0;
            mask_q     <= 4'b0000;
            ready_en_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                lane_a_q[i] <= {width{1'b0}};
                lane_b_q[i] <= {width{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            mask_q     <= mask_d;
            ready_en_q <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                lane_a_q[i] <= lane_a_d[i];
                lane_b_q[i] <= lane_b_d[i];
            end
        end
    end

    assign a0        = lane_a_q[0];
    assign a1        = lane_a_q[1];
    assign a2        = lane_a_q[2];
    assign a3        = lane_a_q[3];
    assign b0        = lane_b_q[0];
    assign b1        = lane_b_q[1];
    assign b2        = lane_b_q[2];
    assign b3        = lane_b_q[3];
    assign lane_mask = mask_q;

endmodule

// File: tb/tb_simd4_operand_packer.sv
// Scoreboard bench for simd4_operand_packer: a small packing model pushes expected bundles,
// each scenario task pops and compares them when the DUT presents a bundle.
module tb_simd4_operand_packer;

    typedef struct packed {
        logic [3:0][11:0] a;
        logic [3:0][11:0] b;
        logic [3:0]       m;
    } bundle_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [11:0] in_a = 12'd0, in_b = 12'd0;
    logic        in_ready, out_valid;
    logic [11:0] a0, a1, a2, a3, b0, b1, b2, b3;
    logic [3:0]  lane_mask;

    logic        in_valid_8 = 1'b0, in_last_8 = 1'b0, out_ready_8 = 1'b0;
    logic [7:0]  in_a_8 = 8'd0, in_b_8 = 8'd0;
    logic        in_ready_8, out_valid_8;
    logic [7:0]  a0_8, a1_8, a2_8, a3_8, b0_8, b1_8, b2_8, b3_8;
    logic [3:0]  lane_mask_8;

    int n_checks = 0;
    int n_pass   = 0;

    bundle_t sb_q[$];
    bundle_t mdl_cur;
    int      mdl_cnt;
    bundle_t obs, exp_b;
    logic    obs_valid, obs_in_ready;

    always #5 clock = ~clock;

    simd4_operand_packer #(.width(12)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3), .lane_mask(lane_mask)
    );

    simd4_operand_packer #(.width(8)) dut8 (
        .clock(clock), .reset(reset), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .in_a(in_a_8), .in_b(in_b_8), .in_last(in_last_8), .out_valid(out_valid_8),
        .out_ready(out_ready_8), .a0(a0_8), .a1(a1_8), .a2(a2_8), .a3(a3_8),
        .b0(b0_8), .b1(b1_8), .b2(b2_8), .b3(b3_8), .lane_mask(lane_mask_8)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sample();
        obs.a        = {a3, a2, a1, a0};
        obs.b        = {b3, b2, b1, b0};
        obs.m        = lane_mask;
        obs_valid    = out_valid;
        obs_in_ready = in_ready;
    endtask

    // Reference packer: records an accepted pair, pushes the bundle when it closes
    task automatic model_accept(input logic [11:0] a, input logic [11:0] b, input logic last);
        mdl_cur.a[mdl_cnt] = a;
        mdl_cur.b[mdl_cnt] = b;
        mdl_cur.m[mdl_cnt] = 1'b1;
        if (mdl_cnt == 3 || last) begin
            sb_q.push_back(mdl_cur);
            mdl_cur = '0;
            mdl_cnt = 0;
        end else begin
            mdl_cnt++;
        end
    endtask

    task automatic model_clear();
        sb_q.delete();
        mdl_cur = '0;
        mdl_cnt = 0;
    endtask

    // Drive inputs for one cycle, sample outputs on the falling edge, then pass the rising edge
    task automatic drive_cycle(input logic v, input logic [11:0] a, input logic [11:0] b,
                               input logic last);
        in_valid = v; in_a = a; in_b = b; in_last = last;
        @(negedge clock);
        sample();
        @(posedge clock);
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic pop_expected();
        exp_b = (sb_q.size() > 0) ? sb_q.pop_front() : '1;
    endtask

    task automatic test_reset();
        model_clear();
        repeat (2) @(posedge clock);
        @(negedge clock);
        sample();
        n_checks++;
        if (obs_valid === 1'b0 && obs === '0) n_pass++;
        else $display("FAIL reset_state: valid=%b bundle=%h want valid=0 bundle=0", obs_valid, obs);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if (in_ready === 1'b1) n_pass++;
        else $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
    endtask

    task automatic test_full_bundle();
        bit ok = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 12'(2*i+1), 12'(2*i+2), 1'b0);
            model_accept(12'(2*i+1), 12'(2*i+2), 1'b0);
            if (obs_valid !== 1'b0 || obs_in_ready !== 1'b1) ok = 1'b0;
        end
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL full_fill: out_valid/in_ready wrong during fill, want 0/1");
        drive_cycle(1'b0, 12'd0, 12'd0, 1'b0);
        pop_expected();
        n_checks++;
        if (obs_valid === 1'b1 && obs === exp_b) n_pass++;
        else $display("FAIL full_bundle: valid=%b got=%h want=%h", obs_valid, obs, exp_b);
        drive_cycle(1'b0, 12'd0, 12'd0, 1'b0);
        n_checks++;
        if (obs_valid === 1'b0 && obs === '0) n_pass++;
        else $display("FAIL full_clear: valid=%b got=%h want valid=0 bundle=0", obs_valid, obs);
    endtask

    task automatic test_short_bundle();
        out_ready = 1'b1;
        drive_cycle(1'b1, 12'd10, 12'd20, 1'b0); model_accept(12'd10, 12'd20, 1'b0);
        drive_cycle(1'b1, 12'd30, 12'd40, 1'b1); model_accept(12'd30, 12'd40, 1'b1);
        drive_cycle(1'b0, 12'd0, 12'd0, 1'b0);
        pop_expected();
        n_checks++;
        if (obs_valid === 1'b1 && obs === exp_b && obs.m === 4'b0011) n_pass++;
        else $display("FAIL short_bundle: valid=%b got=%h want=%h", obs_valid, obs, exp_b);
        drive_cycle(1'b1, 12'd5, 12'd9, 1'b1); model_accept(12'd5, 12'd9, 1'b1);
        drive_cycle(1'b0, 12'd0, 12'd0, 1'b0);
        pop_expected();
        n_checks++;
        if (obs_valid === 1'b1 && obs === exp_b && obs.m === 4'b0001) n_pass++;
        else $display("FAIL single_lane: valid=%b got=%h want=%h", obs_valid, obs, exp_b);
        drive_cycle(1'b0, 12'd0, 12'd0, 1'b0);
    endtask

    task automatic test_hold();
        bit ok = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 12'(12'h100 + i), 12'(12'h200 + i), 1'b0);
            model_accept(12'(12'h100 + i), 12'(12'h200 + i), 1'b0);
        end
        // offered pairs must be refused while the bundle is held
        for (int k = 0; k < 5; k++) begin
            drive_cycle(1'b1, 12'hBAD, 12'hBAD, 1'b1);
            if (obs_valid !== 1'b1 || obs_in_ready !== 1'b0 || obs !== sb_q[0]) ok = 1'b0;
        end
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL hold_stable: valid=%b in_ready=%b got=%h want=%h",
                      obs_valid, obs_in_ready, obs, sb_q[0]);
        out_ready = 1'b1;
        drive_cycle(1'b0, 12'd0, 12'd0, 1'b0);
        pop_expected();
        n_checks++;
        if (obs_valid === 1'b1 && obs === exp_b) n_pass++;
        else $display("FAIL hold_release: valid=%b got=%h want=%h", obs_valid, obs, exp_b);
        drive_cycle(1'b0, 12'd0, 12'd0, 1'b0);
        n_checks++;
        if (obs_valid === 1'b0 && obs.m === 4'b0000) n_pass++;
        else $display("FAIL hold_to_fill: valid=%b mask=%b want 0/0000", obs_valid, obs.m);
    endtask

    task automatic test_continuous();
        bit ok_ready = 1'b1;
        int got = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive_cycle(i < 12, 12'(i), 12'(i + 12), 1'b0);
            if (obs_valid === 1'b1) begin
                pop_expected();
                got++;
                n_checks++;
                if (obs === exp_b) n_pass++;
                else $display("FAIL cont_bundle%0d: got=%h want=%h", got, obs, exp_b);
            end
            if (i < 12) begin
                model_accept(12'(i), 12'(i + 12), 1'b0);
                if (obs_in_ready !== 1'b1) ok_ready = 1'b0;
            end
        end
        n_checks++;
        if (ok_ready && got == 3) n_pass++;
        else $display("FAIL cont_flow: in_ready_ok=%b bundles=%0d want 1/3", ok_ready, got);
    endtask

    task automatic test_back_to_back();
        logic [11:0] sa [6] = '{12'd1, 12'd2, 12'd3, 12'd4, 12'h055, 12'h077};
        logic [11:0] sb [6] = '{12'd9, 12'd8, 12'd7, 12'd6, 12'h066, 12'h088};
        logic        sl [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int got = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i < 6) drive_cycle(1'b1, sa[i], sb[i], sl[i]);
            else       drive_cycle(1'b0, 12'd0, 12'd0, 1'b0);
            if (obs_valid === 1'b1) begin
                pop_expected();
                got++;
                n_checks++;
                if (obs === exp_b) n_pass++;
                else $display("FAIL b2b_bundle%0d: got=%h want=%h", got, obs, exp_b);
            end
            if (i < 6) model_accept(sa[i], sb[i], sl[i]);
        end
        n_checks++;
        if (got == 3 && sb_q.size() == 0) n_pass++;
        else $display("FAIL b2b_count: bundles=%0d left=%0d want 3/0", got, sb_q.size());
    endtask

    task automatic test_reset_mid(input bit in_hold);
        bit ok = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < (in_hold ? 4 : 2); i++) begin
            drive_cycle(1'b1, 12'(12'h300 + i), 12'(12'h400 + i), 1'b0);
            model_accept(12'(12'h300 + i), 12'(12'h400 + i), 1'b0);
        end
        if (in_hold) begin
            drive_cycle(1'b0, 12'd0, 12'd0, 1'b0);
            n_checks++;
            if (obs_valid === 1'b1) n_pass++;
            else $display("FAIL rst_pre_hold: valid=%b want 1", obs_valid);
        end
        #2 reset = 1'b1;
        #1 sample();
        n_checks++;
        if (obs_valid === 1'b0 && obs === '0) n_pass++;
        else $display("FAIL rst_mid_%0s: valid=%b got=%h want 0/0", in_hold ? "hold" : "fill",
                      obs_valid, obs);
        model_clear();
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 12'(12'h500 + i), 12'(12'h600 + i), 1'b0);
            model_accept(12'(12'h500 + i), 12'(12'h600 + i), 1'b0);
            if (obs_valid !== 1'b0 || obs_in_ready !== 1'b1) ok = 1'b0;
        end
        drive_cycle(1'b0, 12'd0, 12'd0, 1'b0);
        pop_expected();
        n_checks++;
        if (ok && obs_valid === 1'b1 && obs === exp_b) n_pass++;
        else $display("FAIL rst_recover: flow_ok=%b valid=%b got=%h want=%h", ok, obs_valid,
                      obs, exp_b);
        drive_cycle(1'b0, 12'd0, 12'd0, 1'b0);
    endtask

    task automatic test_width8();
        out_ready_8 = 1'b0;
        in_valid_8 = 1'b1; in_a_8 = 8'hFF; in_b_8 = 8'h01; in_last_8 = 1'b1;
        @(negedge clock);
        n_checks++;
        if (in_ready_8 === 1'b1 && out_valid_8 === 1'b0) n_pass++;
        else $display("FAIL w8_accept: in_ready=%b valid=%b want 1/0", in_ready_8, out_valid_8);
        @(posedge clock); #1;
        in_valid_8 = 1'b0; in_last_8 = 1'b0;
        @(negedge clock);
        n_checks++;
        if (out_valid_8 === 1'b1 && lane_mask_8 === 4'b0001 &&
            {a3_8, a2_8, a1_8, a0_8} === 32'h0000_00FF &&
            {b3_8, b2_8, b1_8, b0_8} === 32'h0000_0001) n_pass++;
        else $display("FAIL w8_bundle: valid=%b mask=%b a=%h b=%h want 1/0001/000000ff/00000001",
                      out_valid_8, lane_mask_8, {a3_8, a2_8, a1_8, a0_8},
                      {b3_8, b2_8, b1_8, b0_8});
    endtask

    initial begin
        test_reset();
        test_full_bundle();
        test_short_bundle();
        test_hold();
        test_continuous();
        test_back_to_back();
        test_reset_mid(1'b0);
        test_reset_mid(1'b1);
        test_width8();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
